// File: rtl/bus_master_if.sv
// bus_master_if
//   Bus-master front end between a core and the shared two-master bus.
//   Core commands are queued in a small FIFO. While work is pending the
//   block requests the bus (breq_), waits for the grant (bgrt_), and runs
//   one strobe/ready transaction per command. After MAX_BURST transactions
//   it releases the bus so the other master gets a turn.
//
//   Optional feature macro: BUSM_TIMEOUT_EN
//     defined   : an ACCESS that sees no bus_rdy_ for TIMEOUT cycles is
//                 aborted (head popped, rsp_err pulsed, no rsp_valid)
//     undefined : ACCESS waits indefinitely, rsp_err is tied low
//
//   Ports
//     clk, reset_                 clock, synchronous active-low reset
//     req_valid/req_ready         core command handshake (ready = FIFO not full)
//     req_rw/req_addr/req_wdata   command: 1 = read, address, write data
//     rsp_valid/rsp_rdata         one-cycle pulse with read data per read
//     rsp_err                     one-cycle abort pulse
//     breq_/bgrt_                 active-low bus request / grant
//     bus_as_/bus_rw/bus_addr/
//     bus_wdata/bus_rdata/bus_rdy_  strobe/ready bus transaction signals
//     busy                        FIFO non-empty or FSM not idle
module bus_master_if #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              breq_,
  input  logic              bgrt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdy_,
  output logic              busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

  // Reject configurations the pointer arithmetic and counters cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_master_if: invalid DEPTH/MAX_BURST/TIMEOUT");
  end

  typedef enum logic [2:0] {IDLE, REQ, ACCESS, GAP, REL} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic [DEPTH-1:0]  rw_mem;

  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic               rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_rdata_reg;

  logic full, empty, push, pop, done_ok, done_err, head_rw, in_access;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  // A push while full is refused even if a pop happens in the same cycle.
  assign push      = req_valid && !full;
  assign in_access = (state_reg == ACCESS);
  assign head_rw   = rw_mem[rd_ptr_reg];
  assign done_ok   = in_access && !bus_rdy_;
  assign pop       = done_ok || done_err;

`ifdef BUSM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             rsp_err_reg;

  // Counts ACCESS cycles without ready; the TIMEOUT-th such cycle aborts.
  assign done_err = in_access && bus_rdy_ && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
  assign rsp_err  = rsp_err_reg;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      tmo_cnt_reg <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      rsp_err_reg <= done_err;
      if (in_access && !pop)
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      else
        tmo_cnt_reg <= '0;
    end
  end
`else
  assign done_err = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // FIFO storage: data entries need no reset, only pointers and count do.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg]  <= req_addr;
      wdata_mem[wr_ptr_reg] <= req_wdata;
      rw_mem[wr_ptr_reg]    <= req_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      burst_cnt_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= done_ok && head_rw;
      if (done_ok && head_rw)
        rsp_rdata_reg <= bus_rdata;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (state_reg == REL)
        burst_cnt_reg <= '0;
      else if (pop)
        burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
    end
  end

  // breq_/bus_as_ depend on the state register only, so they never glitch.
  always_comb begin
    state_next = state_reg;
    breq_      = 1'b1;
    bus_as_    = 1'b1;
    case (state_reg)
      IDLE: begin
        if (!empty) state_next = REQ;
      end
      REQ: begin
        breq_ = 1'b0;
        if (!bgrt_) state_next = ACCESS;
      end
      ACCESS: begin
        breq_   = 1'b0;
        bus_as_ = 1'b0;
        if (pop) state_next = GAP;
      end
      GAP: begin
        breq_ = 1'b0;
        if (!empty && burst_cnt_reg < MAX_BURST_C) state_next = ACCESS;
        else                                       state_next = REL;
      end
      REL: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus qualifiers are zeroed outside ACCESS; inside they track the FIFO
  // head, which cannot change until the transaction completes.
  assign bus_rw    = in_access ? head_rw               : 1'b0;
  assign bus_addr  = in_access ? addr_mem[rd_ptr_reg]  : '0;
  assign bus_wdata = in_access ? wdata_mem[rd_ptr_reg] : '0;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign busy      = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: scoreboard of queued commands checked against
// the bus strobes, and expected read data checked against rsp_valid/rsp_rdata.
module tb_bus_master_if;
  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset_;
  logic          req_valid, req_ready, req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          breq_, bgrt_, bus_as_, bus_rw, bus_rdy_;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          busy;
  logic          rdy_en;

  cmd_t          exp_q[$];
  logic [DW-1:0] rsp_q[$];
  int            burst_lens[$];
  int            breq_gaps[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            err_cnt = 0;

  always #5 clk = ~clk;

  // Slave model: ready as soon as a strobe appears (when enabled), read
  // data is a fixed function of the address.
  function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {a, 2'b00};
  endfunction

  assign bus_rdy_  = !(rdy_en && !bus_as_);
  assign bus_rdata = rdata_fn(bus_addr);

  bus_master_if #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .MAX_BURST(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_(reset_),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .breq_(breq_), .bgrt_(bgrt_),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdy_(bus_rdy_),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one command for one cycle; acc reports whether it was taken.
  task automatic push_cmd(input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output bit acc);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (acc) exp_q.push_back('{rw: rw, addr: a, wdata: d});
  endtask

  task automatic push_retry(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 50) begin
      push_cmd(rw, a, d, acc);
      tries++;
    end
    check("push_accept", 64'(acc), 64'(1));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy && rsp_q.size() == 0 && exp_q.size() == 0) ok = 1'b1;
    end
    check("drain", 64'(ok), 64'(1));
  endtask

  task automatic wait_as_low();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (!bus_as_) ok = 1'b1;
    end
    check("as_low_wait", 64'(ok), 64'(1));
  endtask

  // Bus monitor / scoreboard, sampled on the falling edge.
  logic prev_as = 1'b1, prev_breq = 1'b1;
  int   strobes = 0, hi_run = 0, breq_hi = 0;

  always @(negedge clk) begin
    if (!reset_) begin
      prev_as = 1'b1; prev_breq = 1'b1; strobes = 0; hi_run = 0; breq_hi = 0;
    end else begin
      if (!bus_as_) begin
        check("strobe_has_cmd", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("bus_rw", 64'(bus_rw), 64'(exp_q[0].rw));
          check("bus_addr", 64'(bus_addr), 64'(exp_q[0].addr));
          check("bus_wdata", 64'(bus_wdata), 64'(exp_q[0].wdata));
          if (!bus_rdy_) begin
            $display("txn %s addr=%h wdata=%h", exp_q[0].rw ? "RD" : "WR",
                     exp_q[0].addr, exp_q[0].wdata);
            if (exp_q[0].rw) rsp_q.push_back(rdata_fn(exp_q[0].addr));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("bus_idle_zero", 64'({bus_rw, bus_addr, bus_wdata}), 64'(0));
      end
      if (rsp_valid) begin
        check("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
        if (rsp_q.size() != 0) check("rsp_rdata", 64'(rsp_rdata), 64'(rsp_q.pop_front()));
      end
      if (rsp_err) begin
`ifdef BUSM_TIMEOUT_EN
        err_cnt++;
        check("err_has_cmd", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          $display("txn ABORT addr=%h", exp_q[0].addr);
          void'(exp_q.pop_front());
        end
`else
        check("rsp_err_tied", 64'(rsp_err), 64'(0));
`endif
      end
      if (!bus_as_ && prev_as) begin
        strobes++;
        if (strobes > 1) check("gap_len", 64'(hi_run), 64'(1));
      end
      hi_run = bus_as_ ? hi_run + 1 : 0;
      if (!breq_ && prev_breq) begin
        breq_gaps.push_back(breq_hi);
        strobes = 0;
      end
      if (breq_ && !prev_breq) burst_lens.push_back(strobes);
      breq_hi   = breq_ ? breq_hi + 1 : 0;
      prev_as   = bus_as_;
      prev_breq = breq_;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    reset_ = 1'b0; req_valid = 1'b1; req_rw = 1'b1; req_addr = 30'h5;
    req_wdata = '0; bgrt_ = 1'b0; rdy_en = 1'b1;

    // Reset held two cycles with a command offered.
    repeat (2) @(posedge clk);
    #1;
    check("rst_breq", 64'(breq_), 64'(1));
    check("rst_as", 64'(bus_as_), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    reset_ = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_no_push", 64'(busy), 64'(0));

    // Minimum-latency read with grant already present.
    push_cmd(1'b1, 30'h0, 32'h0, acc);               // edge 0
    check("rd_acc", 64'(acc), 64'(1));
    @(posedge clk); #1;                              // edge 1
    check("lat_breq_e1", 64'(breq_), 64'(0));
    check("lat_as_e1", 64'(bus_as_), 64'(1));
    @(posedge clk); #1;                              // edge 2
    check("lat_as_e2", 64'(bus_as_), 64'(0));
    @(posedge clk); #1;                              // edge 3
    check("lat_rsp_valid_e3", 64'(rsp_valid), 64'(1));
    check("lat_rsp_rdata_e3", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    check("lat_as_e3", 64'(bus_as_), 64'(1));
    @(posedge clk); #1;                              // edge 4
    check("lat_rsp_valid_e4", 64'(rsp_valid), 64'(0));
    wait_idle();

    // Six writes: burst of MAX_BURST, release, then the remaining two.
    burst_lens.delete();
    breq_gaps.delete();
    for (int i = 0; i < 6; i++) push_retry(1'b0, AW'($urandom), $urandom);
    wait_idle();
    check("burst_count", 64'(burst_lens.size()), 64'(2));
    if (burst_lens.size() == 2) begin
      check("burst0_len", 64'(burst_lens[0]), 64'(4));
      check("burst1_len", 64'(burst_lens[1]), 64'(2));
    end
    check("rereq_seen", 64'(breq_gaps.size() >= 2), 64'(1));
    if (breq_gaps.size() >= 2)
      check("release_len_ok", 64'(breq_gaps[$] >= 1 && breq_gaps[$] <= 2), 64'(1));

    // Grant delayed five cycles after breq_ falls.
    bgrt_ = 1'b1;
    push_cmd(1'b1, 30'h123, 32'h0, acc);
    n = 0;
    while (breq_ && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("gd_breq_low", 64'(breq_), 64'(0));
    repeat (5) begin
      check("gd_as_hi", 64'(bus_as_), 64'(1));
      @(posedge clk); #1;
    end
    check("gd_as_hi_last", 64'(bus_as_), 64'(1));
    bgrt_ = 1'b0;
    @(posedge clk); #1;
    check("gd_as_low", 64'(bus_as_), 64'(0));
    wait_idle();

    // FIFO full with no grant; fifth push refused.
    bgrt_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'(i), AW'(32'h200 + i), $urandom, acc);
      check("full_push_acc", 64'(acc), 64'(1));
    end
    check("full_ready", 64'(req_ready), 64'(0));
    push_cmd(1'b1, 30'h3FF, 32'h0, acc);
    check("full_refused", 64'(acc), 64'(0));
    bgrt_ = 1'b0;
    wait_as_low();
    check("full_ready_access", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("ready_after_pop", 64'(req_ready), 64'(1));
    wait_idle();

    // Slave never ready.
    rdy_en = 1'b0;
    push_cmd(1'b1, 30'h77, 32'h0, acc);
    wait_as_low();
    n = 0;
    while (!bus_as_ && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
`ifdef BUSM_TIMEOUT_EN
    check("tmo_as_cycles", 64'(n), 64'(8));
    check("tmo_err_pulses", 64'(err_cnt), 64'(1));
    check("tmo_fifo_popped", 64'(exp_q.size()), 64'(0));
`else
    check("stuck_as_cycles", 64'(n), 64'(300));
`endif

    // Reset during (or right after) the stuck transfer flushes everything.
    reset_ = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1; rdy_en = 1'b1;
    exp_q.delete();
    rsp_q.delete();
    check("mid_rst_as", 64'(bus_as_), 64'(1));
    check("mid_rst_breq", 64'(breq_), 64'(1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_flushed", 64'({busy, bus_as_, rsp_valid}), 64'(3'b010));

    check("sb_cmds_left", 64'(exp_q.size()), 64'(0));
    check("sb_rsps_left", 64'(rsp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
